uart_wb_arbiter: RTL and testbench

//  Round-robin Wishbone arbiter: NUM_REQ masters share one Wishbone slave port (one uart_top instance).
//  - Masters: wishbone_driver instances or host/DMA ports. Buses are flattened; requester k owns slice k.
//  - The grant is held for a whole cycle (cyc) burst, so a master's register sequence
//    (e.g. LCR/DLL/DLM programming) is never interleaved with another master's.

---
 rtl/uart_wb_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_wb_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_arbiter.sv
// -----------------------------------------------------------------------------
// uart_wb_arbiter
//   Round-robin Wishbone arbiter. NUM_REQ masters share one Wishbone slave
//   port, which is normally a single uart_top instance. A grant lasts for a
//   whole cyc burst. This keeps a multi-register sequence from one master,
//   such as LCR/DLL/DLM programming, from being interleaved with another
//   master's accesses.
//
//   Optional feature macro: UART_ARB_TIMEOUT_EN
//     When defined, a stall counter watches the granted master's strobe.
//     After TIMEOUT_CYC cycles with no ack/err/rty the arbiter does three
//     things for one cycle: it pulses timeout_o, it returns err to the
//     granted master, and it masks s_stb_o. When undefined, timeout_o is
//     tied low and a stalled slave blocks the bus indefinitely.
//
// Ports
//   wb_clk_i, wb_rst_ni          clock; asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i       per-master control, bit k = master k
//   m_adr_i/m_dat_i/m_sel_i      per-master buses, flattened, slice k = master k
//   m_dat_o                      slave read data, broadcast to all masters
//   m_ack_o/m_err_o/m_rty_o      slave responses, routed to the granted master
//   s_cyc_o .. s_sel_o           muxed request toward the slave
//   s_dat_i/s_ack_i/s_err_i/s_rty_i  slave responses
//   grant_o                      one-hot grant (all zero when idle)
//   timeout_o                    one-cycle stall-timeout pulse
// -----------------------------------------------------------------------------
module uart_wb_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic [NUM_REQ-1:0]        m_cyc_i,
  input  logic [NUM_REQ-1:0]        m_stb_i,
  input  logic [NUM_REQ-1:0]        m_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] m_adr_i,
  input  logic [NUM_REQ*DATA_W-1:0] m_dat_i,
  input  logic [NUM_REQ*SEL_W-1:0]  m_sel_i,
  output logic [DATA_W-1:0]         m_dat_o,
  output logic [NUM_REQ-1:0]        m_ack_o,
  output logic [NUM_REQ-1:0]        m_err_o,
  output logic [NUM_REQ-1:0]        m_rty_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [ADDR_W-1:0]         s_adr_o,
  output logic [DATA_W-1:0]         s_dat_o,
  output logic [SEL_W-1:0]          s_sel_o,
  input  logic [DATA_W-1:0]         s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_rty_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      timeout_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cur_q, cur_d;    // index of the granted master
  logic [IDX_W-1:0] last_q, last_d;  // last master that was granted

  // ---------------------------------------------------------------------------
  // Reset synchroniser. Assertion is asynchronous, so the outputs drop to
  // their idle values at once. Deassertion is retimed to the clock, so the
  // arbiter never leaves reset on a partial clock edge.
  // ---------------------------------------------------------------------------
  logic rst_meta_q;
  logic rst_sync_n_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rst_meta_q   <= 1'b0;
      rst_sync_n_q <= 1'b0;
    end else begin
      rst_meta_q   <= 1'b1;
      rst_sync_n_q <= rst_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant decode and per-master masking. An AND-OR mux is used, driven by the
  // one-hot grant. When idle the grant is all zero, so every slave-side
  // request field collapses to zero without needing a separate idle case.
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] gsel;
  logic [ADDR_W-1:0]  adr_masked [NUM_REQ];
  logic [DATA_W-1:0]  dat_masked [NUM_REQ];
  logic [SEL_W-1:0]   sel_masked [NUM_REQ];
  logic               cyc_g;
  logic               stb_g;
  logic               we_g;

  assign gsel  = (state_q == ST_BUSY) ? (NUM_REQ'(1) << cur_q) : '0;
  assign cyc_g = |(m_cyc_i & gsel);
  assign stb_g = |(m_stb_i & gsel);
  assign we_g  = |(m_we_i  & gsel);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign adr_masked[gi] = m_adr_i[gi*ADDR_W +: ADDR_W] & {ADDR_W{gsel[gi]}};
      assign dat_masked[gi] = m_dat_i[gi*DATA_W +: DATA_W] & {DATA_W{gsel[gi]}};
      assign sel_masked[gi] = m_sel_i[gi*SEL_W  +: SEL_W]  & {SEL_W{gsel[gi]}};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin pick. Walk forward from last_q+1, wrapping modulo NUM_REQ,
  // and take the first master that has cyc asserted. The search ends at
  // last_q itself, so a lone requester can win twice in a row.
  // ---------------------------------------------------------------------------
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W:0]   rr_sum;
  logic [IDX_W-1:0] rr_cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_sum     = '0;
    rr_cand    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      rr_sum = {1'b0, last_q} + (IDX_W+1)'(off);
      if (rr_sum >= (IDX_W+1)'(NUM_REQ)) begin
        rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
      end
      rr_cand = rr_sum[IDX_W-1:0];
      if (!pick_found && m_cyc_i[rr_cand]) begin
        pick_found = 1'b1;
        pick_idx   = rr_cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stall timeout
  // ---------------------------------------------------------------------------
  logic hit;   // timeout fires in this cycle
  logic resp;  // slave returned ack, err or rty

  assign resp = s_ack_i | s_err_i | s_rty_i;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int             CNT_W  = 16;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // hit is taken from the counter and the master inputs only, never from the
  // slave response. The slave sees the masked s_stb_o, so if hit depended on
  // the response it would close a combinational loop through the slave.
  assign hit = (state_q == ST_BUSY) & cyc_g & stb_g & (cnt_q == TO_LIM);

  always_comb begin
    cnt_d = '0;
    if ((state_q == ST_BUSY) && cyc_g && stb_g && !resp && !hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_sync_n_q) begin
    if (!rst_sync_n_q) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign hit = 1'b0;

  // Without the timeout, the limit parameter and the combined response are
  // not needed. Reducing them into this net keeps them visibly consumed.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0) ^ resp;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge rst_sync_n_q) begin
    if (!rst_sync_n_q) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);  // requester 0 wins first after reset
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. A release always returns to IDLE for one cycle, and any
  // new request is arbitrated from there. This gives the dead cycle between
  // bursts.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_BUSY;
          cur_d   = pick_idx;
        end
      end
      ST_BUSY: begin
        if (!cyc_g) begin
          state_d = ST_IDLE;
          last_d  = cur_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Slave responses pass through combinationally and are
  // steered by the grant. When several responses are asserted at once they
  // are all forwarded unchanged; no priority is applied.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_cyc_o   = cyc_g;
    s_stb_o   = cyc_g & stb_g & ~hit;
    s_we_o    = we_g;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s_adr_o = s_adr_o | adr_masked[k];
      s_dat_o = s_dat_o | dat_masked[k];
      s_sel_o = s_sel_o | sel_masked[k];
    end
    m_dat_o   = s_dat_i;
    m_ack_o   = gsel & {NUM_REQ{s_ack_i}};
    m_err_o   = gsel & {NUM_REQ{s_err_i | hit}};
    m_rty_o   = gsel & {NUM_REQ{s_rty_i}};
    grant_o   = gsel;
    timeout_o = hit;
  end

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_wb_arbiter
//   Self-checking bench for uart_wb_arbiter with four masters.
//
//   Bench-side masters run bursts of beats. The bench also acts as the slave
//   and answers each strobe. A transaction-level reference model tracks the
//   current owner and the last owner, and predicts every arbiter output on
//   every cycle. The model uses plain integers and modulo arithmetic.
//
//   The run covers the directed scenarios first, then a randomized phase with
//   random bursts, aborts and err/rty responses.
// -----------------------------------------------------------------------------
module tb_uart_wb_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            wb_rst_ni;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0] m_adr_i;
  logic [N*DW-1:0] m_dat_i;
  logic [N*SW-1:0] m_sel_i;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, m_rty_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i, s_err_i, s_rty_i;
  logic [N-1:0]    grant_o;
  logic            timeout_o;

  uart_wb_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .TIMEOUT_CYC(TO)
  ) dut (
    .wb_clk_i (clk),     .wb_rst_ni(wb_rst_ni),
    .m_cyc_i  (m_cyc_i), .m_stb_i  (m_stb_i),  .m_we_i (m_we_i),
    .m_adr_i  (m_adr_i), .m_dat_i  (m_dat_i),  .m_sel_i(m_sel_i),
    .m_dat_o  (m_dat_o), .m_ack_o  (m_ack_o),  .m_err_o(m_err_o),
    .m_rty_o  (m_rty_o), .s_cyc_o  (s_cyc_o),  .s_stb_o(s_stb_o),
    .s_we_o   (s_we_o),  .s_adr_o  (s_adr_o),  .s_dat_o(s_dat_o),
    .s_sel_o  (s_sel_o), .s_dat_i  (s_dat_i),  .s_ack_i(s_ack_i),
    .s_err_i  (s_err_i), .s_rty_i  (s_rty_i),  .grant_o(grant_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // Bench master state
  bit            act [N];
  int            beats [N];
  int            done [N];
  logic [AW-1:0] mst_adr [N];
  logic [DW-1:0] mst_dat [N];
  logic          mst_we [N];
  logic [SW-1:0] mst_sel [N];

  // Reference model state
  int owner;  // -1 when nobody holds the bus
  int last;
  int stall;

  // Bench slave and bookkeeping
  bit            rand_en, hold_ack, clean_resp, force_rd;
  logic [DW-1:0] rd_val;
  int            wait_cnt;
  int            cycle;
  int            grant_log[$];
  logic [DW-1:0] cap_dat;
  logic [N-1:0]  cap_ack;
  int            first_stb_cyc, to_cyc;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic start_burst(input int k, input int nb, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic w);
    act[k]     = 1'b1;
    beats[k]   = nb;
    mst_adr[k] = a;
    mst_dat[k] = d;
    mst_we[k]  = w;
    mst_sel[k] = 4'hF;
  endtask

  task automatic drive_masters();
    for (int k = 0; k < N; k++) begin
      m_cyc_i[k]           = act[k];
      m_stb_i[k]           = act[k];
      m_we_i[k]            = mst_we[k];
      m_adr_i[k*AW +: AW]  = mst_adr[k];
      m_dat_i[k*DW +: DW]  = mst_dat[k];
      m_sel_i[k*SW +: SW]  = mst_sel[k];
    end
  endtask

  // One clock cycle. The task is entered 1 time unit after a rising edge,
  // and it returns at the same point of the next cycle.
  task automatic step();
    logic [N-1:0]  cyc_now;
    logic [N-1:0]  e_grant;
    logic          e_cyc, raw_stb, e_hit, e_stb;
    logic          ack, err, rty;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    logic          e_we;
    int            r;

    // Random phase: masters may start new bursts or abort the one they own.
    if (rand_en) begin
      for (int k = 0; k < N; k++) begin
        if (act[k] && owner == k && $urandom_range(0, 19) == 0) act[k] = 1'b0;
        else if (!act[k] && $urandom_range(0, 3) == 0)
          start_burst(k, $urandom_range(1, 3), AW'($urandom_range(0, 7)),
                      $urandom, 1'($urandom_range(0, 1)));
      end
    end
    drive_masters();
    cyc_now = m_cyc_i;

    // Expected request side
    e_grant = (owner >= 0) ? (N'(1) << owner) : '0;
    e_cyc   = (owner >= 0) ? act[owner] : 1'b0;
    raw_stb = e_cyc;
`ifdef UART_ARB_TIMEOUT_EN
    e_hit   = raw_stb && (stall == TO);
`else
    e_hit   = 1'b0;
`endif
    e_stb   = raw_stb && !e_hit;
    e_adr   = (owner >= 0) ? mst_adr[owner] : '0;
    e_dat   = (owner >= 0) ? mst_dat[owner] : '0;
    e_sel   = (owner >= 0) ? mst_sel[owner] : '0;
    e_we    = (owner >= 0) ? mst_we[owner]  : 1'b0;

    // Bench slave: answers a visible strobe, and never waits more than three
    // cycles unless hold_ack is set.
    ack = 1'b0; err = 1'b0; rty = 1'b0;
    if (e_stb && !hold_ack && (wait_cnt >= 3 || $urandom_range(0, 1) == 1)) begin
      r = clean_resp ? 5 : $urandom_range(0, 9);
      if (r == 0) err = 1'b1;
      else if (r == 1) rty = 1'b1;
      else ack = 1'b1;
    end
    wait_cnt = (e_stb && !(ack || err || rty)) ? wait_cnt + 1 : 0;
    s_ack_i = ack; s_err_i = err; s_rty_i = rty;
    s_dat_i = force_rd ? rd_val : DW'($urandom);

    #1;
    check_eq("grant",   grant_o,   e_grant);
    check_eq("s_cyc",   s_cyc_o,   e_cyc);
    check_eq("s_stb",   s_stb_o,   e_stb);
    check_eq("s_we",    s_we_o,    e_we);
    check_eq("s_adr",   s_adr_o,   e_adr);
    check_eq("s_dat",   s_dat_o,   e_dat);
    check_eq("s_sel",   s_sel_o,   e_sel);
    check_eq("m_ack",   m_ack_o,   ack ? e_grant : '0);
    check_eq("m_err",   m_err_o,   (err || e_hit) ? e_grant : '0);
    check_eq("m_rty",   m_rty_o,   rty ? e_grant : '0);
    check_eq("m_dat",   m_dat_o,   s_dat_i);
    check_eq("timeout", timeout_o, e_hit);

    if (s_stb_o === 1'b1 && first_stb_cyc < 0) first_stb_cyc = cycle;
    if (timeout_o === 1'b1 && to_cyc < 0) to_cyc = cycle;
    if (owner == 3 && ack && force_rd) begin
      cap_dat = m_dat_o;
      cap_ack = m_ack_o;
    end

    // Reference model: stall counter and arbitration, using this cycle's cyc.
    if (raw_stb && !(ack || err || rty) && !e_hit) stall++;
    else stall = 0;
    if (owner < 0) begin
      for (int off = 1; off <= N; off++) begin
        if (owner < 0 && cyc_now[(last + off) % N]) begin
          owner = (last + off) % N;
          grant_log.push_back(owner);
        end
      end
    end else if (!cyc_now[owner]) begin
      last  = owner;
      owner = -1;
    end

    // The master that got a response moves to its next beat, or ends the burst.
    // The beat was driven while the old owner held the bus, so the current
    // e_grant identifies that master.
    for (int k = 0; k < N; k++) begin
      if (e_grant[k] && e_stb_or_hit(e_stb, e_hit) && (ack || err || rty || e_hit)) begin
        beats[k]--;
        done[k]++;
        mst_adr[k] = mst_adr[k] + 1;
        mst_dat[k] = $urandom;
        if (beats[k] == 0) act[k] = 1'b0;
      end
    end

    cycle++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic e_stb_or_hit(input logic s, input logic h);
    return s | h;
  endfunction

  task automatic run_until_idle(input int max_cyc);
    int n = 0;
    bit busy = 1'b1;
    while (busy && n < max_cyc) begin
      step();
      n++;
      busy = (owner >= 0);
      for (int k = 0; k < N; k++) if (act[k]) busy = 1'b1;
    end
    check_eq("idle_bound", busy, 1'b0);
    step();
  endtask

  task automatic do_reset();
    wb_rst_ni = 1'b0;
    #1;
    check_eq("rst_grant", grant_o,   '0);
    check_eq("rst_s_cyc", s_cyc_o,   1'b0);
    check_eq("rst_s_stb", s_stb_o,   1'b0);
    check_eq("rst_adr",   s_adr_o,   '0);
    check_eq("rst_ack",   m_ack_o,   '0);
    check_eq("rst_to",    timeout_o, 1'b0);
    for (int k = 0; k < N; k++) begin
      act[k] = 1'b0; beats[k] = 0;
    end
    drive_masters();
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    owner = -1; last = N - 1; stall = 0; wait_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    wb_rst_ni = 1'b1;
    // Let the reset release clear the synchroniser while nothing is requested.
    repeat (3) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    wb_rst_ni = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    for (int k = 0; k < N; k++) begin
      act[k] = 1'b0; beats[k] = 0; done[k] = 0;
      mst_adr[k] = '0; mst_dat[k] = '0; mst_we[k] = 1'b0; mst_sel[k] = '0;
    end
    rand_en = 1'b0; hold_ack = 1'b0; clean_resp = 1'b1; force_rd = 1'b0;
    rd_val = '0; cycle = 0; first_stb_cyc = -1; to_cyc = -1;
    cap_dat = '0; cap_ack = '0;
    @(posedge clk);
    #1;
    do_reset();

    // 1: master 0 writes 0x83 to address 3
    grant_log.delete();
    start_burst(0, 1, 32'd3, 32'h83, 1'b1);
    run_until_idle(20);
    check_eq("t1_done",  done[0], 1);
    check_eq("t1_nlog",  grant_log.size(), 1);
    if (grant_log.size() == 1) check_eq("t1_first", grant_log[0], 0);

    // 2: four simultaneous requests straight after reset are served 0,1,2,3
    do_reset();
    grant_log.delete();
    d0 = done[0] + done[1] + done[2] + done[3];
    for (int k = 0; k < N; k++) start_burst(k, 1, AW'(k), DW'(32'hA0 + k), 1'b1);
    run_until_idle(60);
    check_eq("t2_xfers", done[0] + done[1] + done[2] + done[3] - d0, 4);
    check_eq("t2_nlog",  grant_log.size(), 4);
    if (grant_log.size() == 4)
      for (int i = 0; i < 4; i++) check_eq("t2_order", grant_log[i], i);

    // 3: master 2 runs a 3-beat burst while master 1 waits for it to finish
    grant_log.delete();
    d0 = done[2];
    start_burst(2, 3, 32'd3, 32'h83, 1'b1);
    step();
    start_burst(1, 1, 32'd0, 32'h11, 1'b1);
    run_until_idle(60);
    check_eq("t3_beats", done[2] - d0, 3);
    check_eq("t3_nlog",  grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check_eq("t3_first",  grant_log[0], 2);
      check_eq("t3_second", grant_log[1], 1);
    end

    // 4: reset during a burst owned by master 1; requester 0 wins afterwards
    hold_ack = 1'b1;
    start_burst(1, 4, 32'd0, 32'h55, 1'b1);
    for (int i = 0; i < 4; i++) step();
    check_eq("t4_owner", grant_o, 4'b0010);
    do_reset();
    hold_ack = 1'b0;
    grant_log.delete();
    start_burst(0, 1, 32'd1, 32'h01, 1'b1);
    start_burst(1, 1, 32'd2, 32'h02, 1'b1);
    start_burst(3, 1, 32'd3, 32'h03, 1'b1);
    run_until_idle(60);
    if (grant_log.size() > 0) check_eq("t4_first", grant_log[0], 0);
    else check_eq("t4_nlog", grant_log.size(), 3);

    // 5: master 3 reads LSR at address 5, and the slave returns 0x60
    force_rd = 1'b1; rd_val = 32'h60;
    start_burst(3, 1, 32'd5, 32'h0, 1'b0);
    run_until_idle(20);
    force_rd = 1'b0;
    check_eq("t5_dat", cap_dat, 32'h60);
    check_eq("t5_ack", cap_ack, 4'b1000);

`ifdef UART_ARB_TIMEOUT_EN
    // 6: slave never answers; the timeout pulses 16 cycles after the first strobe
    hold_ack = 1'b1;
    first_stb_cyc = -1; to_cyc = -1;
    start_burst(0, 1, 32'd2, 32'h77, 1'b1);
    run_until_idle(60);
    hold_ack = 1'b0;
    check_eq("t6_seen",  (to_cyc >= 0) && (first_stb_cyc >= 0), 1'b1);
    check_eq("t6_delay", to_cyc - first_stb_cyc, TO);
`endif

    // Randomized phase: random bursts, aborts, and err/rty responses
    rand_en = 1'b1; clean_resp = 1'b0;
    repeat (400) step();
    rand_en = 1'b0;
    run_until_idle(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
